ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xED LED set,
//  0xFF reset). Counterpart to the existing keyboard receive path; shares the PS2_CLK/PS2_DATA

---
 rtl/ps2_pkg.sv | 8 +
 rtl/ps2_line_filter.sv | 31 +++
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host transmitter state encoding and keyboard command constants
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_REL} txState_t;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] ACK_CODE = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer, stability filter and falling-edge pulse for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lineIn,
  output logic level,
  output logic fall
);
  localparam int W = $clog2(FILTER_LEN + 1);
  localparam logic [W-1:0] LAST = W'(FILTER_LEN - 1);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b1;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], lineIn};
      fall <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= sync[1];
        fall <= level;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter over open-drain clk/data enables
// Define PS2_TX_RETRY_EN to retry up to MAX_RETRY times after NACK or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN = 4
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRY = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam logic [19:0] INH_PRE = 20'(INHIBIT_CYCLES - 2);
  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
  txState_t state;
  logic [7:0] shReg;
  logic parBit, fail;
  logic [3:0] bitCnt;
  logic [19:0] cnt;
  logic clkLvl, clkFall, dataLvl, dataFall;
`ifdef PS2_TX_RETRY_EN
  logic [7:0] txByte;
  logic [3:0] retry;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uClk (
    .clk(clk), .reset(reset), .lineIn(ps2_clk_in), .level(clkLvl), .fall(clkFall)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) uData (
    .clk(clk), .reset(reset), .lineIn(ps2_data_in), .level(dataLvl), .fall(dataFall)
  );

  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      tx_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      shReg <= '0;
      parBit <= 1'b0;
      fail <= 1'b0;
      bitCnt <= '0;
      cnt <= '0;
`ifdef PS2_TX_RETRY_EN
      txByte <= '0;
      retry <= '0;
`endif
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef PS2_TX_RETRY_EN
          retry <= '0;
          txByte <= tx_data;
`endif
          if (tx_valid) begin
            shReg <= tx_data;
            parBit <= ~^tx_data;
            fail <= 1'b0;
            bitCnt <= '0;
            ps2_clk_oe <= 1'b1;
            busy <= 1'b1;
            tx_ready <= 1'b0;
            state <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == INH_PRE) ps2_data_oe <= 1'b1;
          if (cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b1;
            cnt <= '0;
            state <= REQ;
          end
        end
        // dataFall implies dataLvl low; it only guards against a line still settling
        WAIT_REL: if (clkLvl && dataLvl && !dataFall) begin
`ifdef PS2_TX_RETRY_EN
          if (fail && retry < 4'(MAX_RETRY)) begin
            retry <= retry + 1'b1;
            shReg <= txByte;
            fail <= 1'b0;
            bitCnt <= '0;
            cnt <= '0;
            ps2_clk_oe <= 1'b1;
            state <= INHIBIT;
          end else
`endif
          begin
            done <= ~fail;
            err <= fail;
            busy <= 1'b0;
            tx_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          if (clkFall) begin
            cnt <= '0;
            if (state == REQ || (state == DATA && bitCnt < 4'd8)) begin
              ps2_data_oe <= ~shReg[0];
              shReg <= {1'b0, shReg[7:1]};
              bitCnt <= bitCnt + {3'b0, bitCnt != 4'hF};
              state <= DATA;
            end else if (state == DATA) begin
              ps2_data_oe <= ~parBit;
              state <= PARITY;
            end else if (state == PARITY) begin
              ps2_data_oe <= 1'b0;
              state <= STOP;
            end else if (state == STOP) state <= ACK;
            else begin
              fail <= dataLvl;
              state <= WAIT_REL;
            end
          end else if (cnt == TMO_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_data_oe <= 1'b0;
            fail <= 1'b1;
            state <= WAIT_REL;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model driving the bus
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int TMO = 3000;
  localparam int H = 30;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif
  logic clk = 0, reset = 1, tx_valid = 0;
  logic [7:0] tx_data = '0;
  logic tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic devClk = 1, devData = 1;
  logic psClk, psData;
  int nChecks = 0, nFail = 0, doneCnt = 0, errCnt = 0, bothCnt = 0, eDone = 0, eErr = 0;
  int inh, k;
  logic [9:0] got;

  assign psClk = devClk & ~ps2_clk_oe;
  assign psData = devData & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err), .ps2_clk_in(psClk), .ps2_data_in(psData),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done) doneCnt++;
    if (err) errCnt++;
    if (done && err) bothCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    check("readyBeforeSend", tx_ready, 1);
    tx_data = b;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
  endtask

  task automatic waitReq(output int len);
    int t = 0;
    len = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    while (ps2_clk_oe && len < 10000) begin @(negedge clk); len++; end
  endtask

  task automatic devFrame(input int n, input logic ackBit, input logic glitch, output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 11) devData = ackBit;
      waitCycles(H);
      devClk = 0;
      waitCycles(H);
      devClk = 1;
      if (i < 10) bits[i] = psData;
      if (glitch && i == 4) begin
        waitCycles(10);
        devClk = 0;
        waitCycles(2);
        devClk = 1;
      end
    end
    waitCycles(H);
    devData = 1;
  endtask

  task automatic finishTx();
    int t = 0;
    while (busy && t < 500) begin @(negedge clk); t++; end
    check("releaseBusy", busy, 0);
    waitCycles(2);
    check("doneCount", doneCnt, eDone);
    check("errCount", errCnt, eErr);
    check("doneErrTogether", bothCnt, 0);
    check("idleClkOe", ps2_clk_oe, 0);
    check("idleDataOe", ps2_data_oe, 0);
    check("readyAfter", tx_ready, 1);
  endtask

  task automatic fullSend(input logic [7:0] b, input logic [9:0] expBits, input logic glitch, input logic poke);
    sendByte(b);
    waitReq(inh);
    check("inhibitLen", inh, INH);
    check("startBitOe", ps2_data_oe, 1);
    check("startBitBus", psData, 0);
    if (poke) begin
      tx_data = 8'h00;
      tx_valid = 1;
      waitCycles(2);
      tx_valid = 0;
    end
    devFrame(12, 1'b0, glitch, got);
    check("frameBits", got, expBits);
    check("readyLowInFrame", tx_ready, 0);
    check("busyInFrame", busy, 1);
    eDone++;
    finishTx();
  endtask

  initial begin
    waitCycles(3);
    check("rstReady", tx_ready, 1);
    check("rstBusy", busy, 0);
    check("rstDone", done, 0);
    check("rstErr", err, 0);
    check("rstClkOe", ps2_clk_oe, 0);
    check("rstDataOe", ps2_data_oe, 0);
    reset = 0;
    waitCycles(10);
    fullSend(8'hED, 10'h3ED, 1'b0, 1'b1);
    fullSend(8'h01, 10'h201, 1'b0, 1'b0);
    fullSend(8'h00, 10'h300, 1'b0, 1'b0);
    fullSend(8'h3C, 10'h33C, 1'b1, 1'b0);
`ifndef PS2_TX_RETRY_EN
    sendByte(8'h55);
    waitReq(inh);
    check("tmoInhibitLen", inh, INH);
    k = 0;
    while (!err && k < TMO + 200) begin @(negedge clk); k++; end
    check("tmoWindow", (k >= TMO + 1 && k <= TMO + 12), 1);
    check("tmoClkOe", ps2_clk_oe, 0);
    check("tmoDataOe", ps2_data_oe, 0);
    eErr++;
    finishTx();
`endif
    sendByte(8'hFE);
    for (int a = 0; a < ATTEMPTS; a++) begin
      waitReq(inh);
      check("nackInhibitLen", inh, INH);
      devFrame(12, 1'b1, 1'b0, got);
      check("nackFrameBits", got, 10'h2FE);
    end
    eErr++;
    finishTx();
    sendByte(8'hA5);
    waitReq(inh);
    devFrame(4, 1'b1, 1'b0, got);
    check("partialBits", got[3:0], 4'h5);
    reset = 1;
    @(negedge clk);
    check("midRstClkOe", ps2_clk_oe, 0);
    check("midRstDataOe", ps2_data_oe, 0);
    check("midRstReady", tx_ready, 1);
    check("midRstBusy", busy, 0);
    reset = 0;
    waitCycles(20);
    check("midRstDone", doneCnt, eDone);
    check("midRstErr", errCnt, eErr);
    fullSend(8'hFF, 10'h3FF, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
